sha256_digest_reader: RTL and testbench

- Read-side counterpart of the hash-state registers (H0..H7).
- On a `load` pulse it captures the 256-bit digest snapshot and streams it out as eight 32-bit words over a valid/ready interface, H0 first.
- Sits between the SHA-256 core's final-state registers and the host/output bus.
- Frees the core to start the next message as soon as the snapshot is taken.

---
 rtl/sha256_pkg.sv | 14 +
 rtl/sha256_word_mux.sv | 24 ++
 rtl/sha256_digest_reader.sv | 102 ++++++++++
 tb/tb_sha256_digest_reader.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants and the digest-reader state type.
// Imported by the reader top level and the word selector.
package sha256_pkg;

   localparam int SHA256_WORD_W       = 32;
   localparam int SHA256_DIGEST_WORDS = 8;
   localparam int SHA256_IDX_W        = 3;

   typedef enum logic {
      RD_IDLE,
      RD_SEND
   } rd_state_t;

endpackage

// File: rtl/sha256_word_mux.sv
// Combinational selector that picks one 32-bit word out of a packed 256-bit block.
// Word 0 is the most significant word, which matches the H0-first digest layout.
module sha256_word_mux
   import sha256_pkg::*;
#(
   parameter int WORD_W    = SHA256_WORD_W,
   parameter int NUM_WORDS = SHA256_DIGEST_WORDS,
   parameter int IDX_W     = SHA256_IDX_W
) (
   input  logic [WORD_W*NUM_WORDS-1:0] data_i,
   input  logic [IDX_W-1:0]            sel,
   output logic [WORD_W-1:0]           word_o
);

   always_comb begin
      word_o = '0;
      for (int i = 0; i < NUM_WORDS; i++) begin
         if (sel == IDX_W'(i)) begin
            word_o = data_i[(NUM_WORDS-1-i)*WORD_W +: WORD_W];
         end
      end
   end

endmodule

// File: rtl/sha256_digest_reader.sv
// Captures the SHA-256 H0..H7 snapshot on load and streams it out H0 first over valid/ready.
// The core is free to reuse its state registers as soon as the snapshot has been taken.
module sha256_digest_reader
   import sha256_pkg::*;
#(
   parameter int WORD_W    = SHA256_WORD_W,
   parameter int NUM_WORDS = SHA256_DIGEST_WORDS,
   parameter int IDX_W     = SHA256_IDX_W
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic                        load,
   input  logic [WORD_W*NUM_WORDS-1:0] digest_i,
   output logic                        busy,
   output logic                        dout_valid,
   input  logic                        dout_ready,
   output logic [WORD_W-1:0]           dout_data,
   output logic [IDX_W-1:0]            dout_idx,
   output logic                        dout_last,
   output logic                        done,
   output logic                        load_err
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

   rd_state_t                   state, state_nx;
   logic [WORD_W*NUM_WORDS-1:0] snap, snap_nx;
   logic [IDX_W-1:0]            idx, idx_nx;
   logic                        done_nx, load_err_nx;
   logic                        hs, last_hs;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= RD_IDLE;
         snap     <= '0;
         idx      <= '0;
         done     <= 1'b0;
         load_err <= 1'b0;
      end else begin
         state    <= state_nx;
         snap     <= snap_nx;
         idx      <= idx_nx;
         done     <= done_nx;
         load_err <= load_err_nx;
      end
   end

   // A load arriving with the final handshake chains straight into the next transfer.
   always_comb begin
      state_nx    = state;
      snap_nx     = snap;
      idx_nx      = idx;
      done_nx     = 1'b0;
      load_err_nx = 1'b0;
      hs          = (state == RD_SEND) && dout_ready;
      last_hs     = hs && (idx == LAST_IDX);
      case (state)
         RD_IDLE: begin
            if (load) begin
               state_nx = RD_SEND;
               snap_nx  = digest_i;
               idx_nx   = '0;
            end
         end
         RD_SEND: begin
            if (last_hs) begin
               done_nx = 1'b1;
               if (load) begin
                  snap_nx = digest_i;
                  idx_nx  = '0;
               end else begin
                  state_nx = RD_IDLE;
               end
            end else begin
               if (hs) begin
                  idx_nx = idx + IDX_W'(1);
               end
               if (load) begin
                  load_err_nx = 1'b1;
               end
            end
         end
         default: state_nx = RD_IDLE;
      endcase
   end

   assign dout_valid = (state == RD_SEND);
   assign busy       = (state == RD_SEND);
   assign dout_idx   = idx;
   assign dout_last  = (state == RD_SEND) && (idx == LAST_IDX);

   sha256_word_mux #(
      .WORD_W    (WORD_W),
      .NUM_WORDS (NUM_WORDS),
      .IDX_W     (IDX_W)
   ) u_word_mux (
      .data_i (snap),
      .sel    (idx),
      .word_o (dout_data)
   );

endmodule

// File: tb/tb_sha256_digest_reader.sv
// Directed self-checking bench for the digest reader using the SHA-256 "abc" and "" digests.
// Inputs change 1 time unit after the rising edge and outputs are sampled there too.
module tb_sha256_digest_reader;
   import sha256_pkg::*;

   localparam logic [255:0] ABC   = 256'hBA7816BF_8F01CFEA_414140DE_5DAE2223_B00361A3_96177A9C_B410FF61_F20015AD;
   localparam logic [255:0] EMPTY = 256'hE3B0C442_98FC1C14_9AFBF4C8_996FB924_27AE41E4_649B934C_A495991B_7852B855;

   logic         CLK = 1'b0;
   logic         RST = 1'b0;
   logic         load = 1'b0;
   logic [255:0] digest_i = '0;
   logic         dout_ready = 1'b0;
   logic         busy, dout_valid, dout_last, done, load_err;
   logic [31:0]  dout_data;
   logic [2:0]   dout_idx;

   int checks = 0;
   int passed = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   sha256_digest_reader dut (
      .CLK        (CLK),
      .RST        (RST),
      .load       (load),
      .digest_i   (digest_i),
      .busy       (busy),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .dout_data  (dout_data),
      .dout_idx   (dout_idx),
      .dout_last  (dout_last),
      .done       (done),
      .load_err   (load_err)
   );

   function automatic logic [31:0] wordOf(input logic [255:0] d, input int i);
      return d[255-32*i -: 32];
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic applyStimulus(input logic ld, input logic [255:0] dig, input logic rdy);
      load       = ld;
      digest_i   = dig;
      dout_ready = rdy;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         failures++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Streams words start..7 with ready held high, checking every beat.
   task automatic streamWords(input string tag, input logic [255:0] d, input int start);
      for (int i = start; i < 8; i++) begin
         checkOutput({tag, "_valid"}, 32'(dout_valid), 32'd1);
         checkOutput({tag, "_data"}, dout_data, wordOf(d, i));
         checkOutput({tag, "_idx"}, 32'(dout_idx), 32'(i));
         checkOutput({tag, "_last"}, 32'(dout_last), (i == 7) ? 32'd1 : 32'd0);
         tick();
      end
   endtask

   initial begin
      int expIdx;
      int handshakes;

      // Reset state
      #1 RST = 1'b1;
      #2;
      checkOutput("rst_valid", 32'(dout_valid), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_loaderr", 32'(load_err), 32'd0);
      checkOutput("rst_data", dout_data, 32'd0);
      checkOutput("rst_last", 32'(dout_last), 32'd0);
      tick();
      tick();
      RST = 1'b0;
      tick();

      // 1: full-rate transfer
      $display("[TB] test 1: back-to-back transfer");
      applyStimulus(1'b1, ABC, 1'b1);
      tick();
      applyStimulus(1'b0, ABC, 1'b1);
      checkOutput("t1_busy", 32'(busy), 32'd1);
      streamWords("t1", ABC, 0);
      checkOutput("t1_done", 32'(done), 32'd1);
      checkOutput("t1_valid_after", 32'(dout_valid), 32'd0);
      checkOutput("t1_busy_after", 32'(busy), 32'd0);
      tick();
      checkOutput("t1_done_once", 32'(done), 32'd0);

      // 2: ready pattern 1,0,0 repeating
      $display("[TB] test 2: stalled transfer");
      applyStimulus(1'b1, ABC, 1'b0);
      tick();
      load = 1'b0;
      expIdx = 0;
      handshakes = 0;
      for (int c = 0; c < 40 && expIdx < 8; c++) begin
         dout_ready = (c % 3 == 0);
         checkOutput("t2_valid", 32'(dout_valid), 32'd1);
         checkOutput("t2_data", dout_data, wordOf(ABC, expIdx));
         checkOutput("t2_idx", 32'(dout_idx), 32'(expIdx));
         if (dout_ready) begin
            expIdx++;
            handshakes++;
         end
         tick();
      end
      checkOutput("t2_handshakes", 32'(handshakes), 32'd8);
      checkOutput("t2_done", 32'(done), 32'd1);
      checkOutput("t2_valid_after", 32'(dout_valid), 32'd0);
      dout_ready = 1'b0;
      tick();

      // 3: load while word 3 is on the bus is rejected
      $display("[TB] test 3: load during transfer");
      applyStimulus(1'b1, ABC, 1'b1);
      tick();
      load = 1'b0;
      streamWords("t3a", ABC, 0);
      checkOutput("t3_wait", 32'(done), 32'd1);
      tick();
      applyStimulus(1'b1, ABC, 1'b1);
      tick();
      load = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      checkOutput("t3_idx3", 32'(dout_idx), 32'd3);
      applyStimulus(1'b1, EMPTY, 1'b1);
      tick();
      applyStimulus(1'b0, EMPTY, 1'b1);
      checkOutput("t3_loaderr", 32'(load_err), 32'd1);
      checkOutput("t3_data4", dout_data, wordOf(ABC, 4));
      checkOutput("t3_idx4", 32'(dout_idx), 32'd4);
      tick();
      checkOutput("t3_loaderr_once", 32'(load_err), 32'd0);
      streamWords("t3b", ABC, 5);
      checkOutput("t3_done", 32'(done), 32'd1);
      tick();

      // 4: load coincident with the final handshake chains transfers
      $display("[TB] test 4: chained load");
      applyStimulus(1'b1, ABC, 1'b1);
      tick();
      load = 1'b0;
      streamWords("t4a", ABC, 0);
      checkOutput("t4_done_a", 32'(done), 32'd1);
      applyStimulus(1'b1, ABC, 1'b1);
      tick();
      load = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      checkOutput("t4_idx7", 32'(dout_idx), 32'd7);
      applyStimulus(1'b1, EMPTY, 1'b1);
      tick();
      applyStimulus(1'b0, ABC, 1'b1);
      checkOutput("t4_done", 32'(done), 32'd1);
      checkOutput("t4_loaderr", 32'(load_err), 32'd0);
      streamWords("t4b", EMPTY, 0);
      checkOutput("t4_done_b", 32'(done), 32'd1);
      tick();
      checkOutput("t4_idle", 32'(dout_valid), 32'd0);

      // 5: async reset at idx 5
      $display("[TB] test 5: reset mid-transfer");
      applyStimulus(1'b1, ABC, 1'b1);
      tick();
      load = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      checkOutput("t5_idx5", 32'(dout_idx), 32'd5);
      #2 RST = 1'b1;
      #1;
      checkOutput("t5_valid", 32'(dout_valid), 32'd0);
      checkOutput("t5_busy", 32'(busy), 32'd0);
      checkOutput("t5_done", 32'(done), 32'd0);
      checkOutput("t5_data", dout_data, 32'd0);
      tick();
      RST = 1'b0;
      tick();
      checkOutput("t5_no_done", 32'(done), 32'd0);
      checkOutput("t5_idle", 32'(dout_valid), 32'd0);
      applyStimulus(1'b1, EMPTY, 1'b1);
      tick();
      load = 1'b0;
      streamWords("t5", EMPTY, 0);
      checkOutput("t5_done_new", 32'(done), 32'd1);
      tick();

      // 6: digest_i churns after capture
      $display("[TB] test 6: snapshot isolation");
      applyStimulus(1'b1, ABC, 1'b1);
      tick();
      load = 1'b0;
      for (int i = 0; i < 8; i++) begin
         digest_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         checkOutput("t6_data", dout_data, wordOf(ABC, i));
         checkOutput("t6_idx", 32'(dout_idx), 32'(i));
         tick();
      end
      checkOutput("t6_done", 32'(done), 32'd1);
      tick();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
